// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned MC_TIMEOUT = 64;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned TIMER_W    = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    StRun,
    StMcWait,
    StMemWait
  } state_e;

  // Field order matches the output port order, MSB first.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_bubble;
  } ctl_t;

  localparam ctl_t CTL_NORMAL   = ctl_t'(7'b110_1010);
  localparam ctl_t CTL_RESET    = ctl_t'(7'b001_0101);
  localparam ctl_t CTL_HOLD     = ctl_t'(7'b000_0000);
  localparam ctl_t CTL_MC_WAIT  = ctl_t'(7'b000_0011);
  localparam ctl_t CTL_REDIRECT = ctl_t'(7'b111_1110);
  localparam ctl_t CTL_LOAD_USE = ctl_t'(7'b000_1110);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clock,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, redirect, multi-cycle EX ops and
// data-memory back-pressure, with stall/redirect statistics.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_mc_start,
  input  logic        ex_mc_done,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        ex_mem_bubble,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count,
  output logic        mc_timeout,
  output logic        protocol_err
);

  state_e               state_d, state_q;
  state_e               resume_d, resume_q;
  state_e               eff_state;
  logic [TIMER_W-1:0]   timer_d, timer_q;
  logic                 mc_timeout_d, mc_timeout_q;
  logic                 protocol_err_d, protocol_err_q;
  logic                 load_use;
  logic                 mc_expired;
  logic                 mc_release;
  logic                 redirect_served;
  ctl_t                 ctl;

  // MEM_WAIT is a memory stall layered over RUN/MC_WAIT; once memory is
  // ready again the remembered state governs this cycle's behaviour.
  assign eff_state = (state_q == StMemWait) ? resume_q : state_q;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign mc_expired      = (timer_q == TIMER_W'(MC_TIMEOUT));
  assign mc_release      = (eff_state == StMcWait) && (ex_mc_done || mc_expired);
  assign redirect_served = !reset && mem_ready && (eff_state == StRun) && ex_redirect;

  always_ff @(posedge clock) begin
    state_q        <= state_d;
    resume_q       <= resume_d;
    timer_q        <= timer_d;
    mc_timeout_q   <= mc_timeout_d;
    protocol_err_q <= protocol_err_d;
  end

  always_comb begin
    state_d        = state_q;
    resume_d       = resume_q;
    timer_d        = timer_q;
    mc_timeout_d   = mc_timeout_q;
    protocol_err_d = protocol_err_q;
    if (reset) begin
      state_d        = StRun;
      resume_d       = StRun;
      timer_d        = '0;
      mc_timeout_d   = 1'b0;
      protocol_err_d = 1'b0;
    end else begin
      if (ex_mc_done && (eff_state != StMcWait)) begin
        protocol_err_d = 1'b1;
      end
      if (ex_redirect && ex_mc_start && (eff_state == StRun)) begin
        protocol_err_d = 1'b1;
      end
      if (!mem_ready) begin
        state_d  = StMemWait;
        resume_d = eff_state;
      end else begin
        unique case (eff_state)
          StMcWait: begin
            if (mc_release) begin
              state_d = StRun;
              timer_d = '0;
              if (!ex_mc_done) begin
                mc_timeout_d = 1'b1;
              end
            end else begin
              state_d = StMcWait;
              timer_d = timer_q + TIMER_W'(1);
            end
          end
          default: begin
            state_d = StRun;
            if (ex_mc_start && !ex_redirect) begin
              state_d = StMcWait;
              timer_d = '0;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    ctl = CTL_NORMAL;
    if (reset) begin
      ctl = CTL_RESET;
    end else if (!mem_ready) begin
      ctl = CTL_HOLD;
    end else if (eff_state == StMcWait) begin
      ctl = mc_release ? CTL_NORMAL : CTL_MC_WAIT;
    end else if (ex_redirect) begin
      ctl = CTL_REDIRECT;
    end else if (load_use) begin
      ctl = CTL_LOAD_USE;
    end
  end

  assign pc_en         = ctl.pc_en;
  assign if_id_en      = ctl.if_id_en;
  assign if_id_flush   = ctl.if_id_flush;
  assign id_ex_en      = ctl.id_ex_en;
  assign id_ex_flush   = ctl.id_ex_flush;
  assign ex_mem_en     = ctl.ex_mem_en;
  assign ex_mem_bubble = ctl.ex_mem_bubble;
  assign mc_timeout    = mc_timeout_q;
  assign protocol_err  = protocol_err_q;

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .clr_i   (reset),
    .inc_i   (!ctl.pc_en),
    .count_o (stall_cycles)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_redirect_cnt (
    .clock   (clock),
    .clr_i   (reset),
    .inc_i   (redirect_served),
    .count_o (redirect_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; inputs change and outputs are
// sampled around the falling clock edge.
module tb_pipeline_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_mem_read, ex_redirect, ex_mc_start, ex_mc_done, mem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_bubble;
  logic [31:0] stall_cycles, redirect_count;
  logic        mc_timeout, protocol_err;
  logic [6:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_bubble}
  localparam logic [6:0] E_NORMAL   = 7'b110_1010;
  localparam logic [6:0] E_RESET    = 7'b001_0101;
  localparam logic [6:0] E_HOLD     = 7'b000_0000;
  localparam logic [6:0] E_MC_WAIT  = 7'b000_0011;
  localparam logic [6:0] E_REDIRECT = 7'b111_1110;
  localparam logic [6:0] E_LOAD_USE = 7'b000_1110;

  always #5 clock = ~clock;

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_bubble};

  pipeline_hazard_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_redirect    (ex_redirect),
    .ex_mc_start    (ex_mc_start),
    .ex_mc_done     (ex_mc_done),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_en      (ex_mem_en),
    .ex_mem_bubble  (ex_mem_bubble),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count),
    .mc_timeout     (mc_timeout),
    .protocol_err   (protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    ex_rd       = 5'd0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0;
    ex_redirect = 1'b0;
    ex_mc_start = 1'b0;
    ex_mc_done  = 1'b0;
    mem_ready   = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Run n cycles with current inputs, expecting a fixed control pattern.
  task automatic run_cycles(input int n, input logic [6:0] exp, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      #1;
      if (ctl !== exp) bad++;
      step();
    end
    check(tag, bad, 0);
  endtask

  task automatic start_mc();
    ex_mc_start = 1'b1;
    #1 check("mc_start_cycle", ctl, E_NORMAL);
    step();
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    step();
    #1 check("rst_ctl", ctl, E_RESET);
    check("rst_stall", stall_cycles, 0);
    check("rst_redir", redirect_count, 0);
    check("rst_flags", {mc_timeout, protocol_err}, 0);
    reset = 1'b0;
    #1 check("run_normal", ctl, E_NORMAL);

    // Load-use on rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    #1 check("lu_ctl", ctl, E_LOAD_USE);
    step();
    idle_inputs();
    #1 check("lu_one_bubble", ctl, E_NORMAL);
    check("lu_stall", stall_cycles, 1);

    // x0 destination and unread source never stall
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    #1 check("lu_x0", ctl, E_NORMAL);
    step();
    ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b0;
    #1 check("lu_unused", ctl, E_NORMAL);
    step();
    idle_inputs();
    check("lu_x0_stall", stall_cycles, 1);

    // Redirect overrides load-use
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; ex_redirect = 1'b1;
    #1 check("redir_ctl", ctl, E_REDIRECT);
    step();
    idle_inputs();
    #1 check("redir_count", redirect_count, 1);
    check("redir_stall", stall_cycles, 1);

    // Multi-cycle op completing after 10 stall cycles
    do_reset();
    start_mc();
    run_cycles(10, E_MC_WAIT, "mc_wait10");
    ex_mc_done = 1'b1;
    #1 check("mc_done_release", ctl, E_NORMAL);
    step();
    idle_inputs();
    #1 check("mc_back_run", ctl, E_NORMAL);
    check("mc_stall10", stall_cycles, 10);
    check("mc_flags", {mc_timeout, protocol_err}, 0);

    // Multi-cycle op timing out
    do_reset();
    start_mc();
    run_cycles(64, E_MC_WAIT, "tmo_wait64");
    #1 check("tmo_release", ctl, E_NORMAL);
    check("tmo_flag_pre", mc_timeout, 0);
    step();
    #1 check("tmo_flag", mc_timeout, 1);
    check("tmo_run", ctl, E_NORMAL);
    check("tmo_stall", stall_cycles, 64);

    // Memory stall inside MC_WAIT freezes the timer
    do_reset();
    start_mc();
    run_cycles(5, E_MC_WAIT, "mem_mc_pre");
    mem_ready = 1'b0;
    run_cycles(3, E_HOLD, "mem_hold3");
    mem_ready = 1'b1;
    run_cycles(59, E_MC_WAIT, "mem_mc_post");
    #1 check("mem_tmo_release", ctl, E_NORMAL);
    step();
    #1 check("mem_tmo_flag", mc_timeout, 1);
    check("mem_stall", stall_cycles, 67);

    // Redirect together with mc_start
    do_reset();
    ex_redirect = 1'b1; ex_mc_start = 1'b1;
    #1 check("rs_ctl", ctl, E_REDIRECT);
    step();
    idle_inputs();
    #1 check("rs_no_mc", ctl, E_NORMAL);
    check("rs_perr", protocol_err, 1);
    check("rs_count", redirect_count, 1);

    // Stray done outside MC_WAIT
    do_reset();
    #1 check("done_perr_clr", protocol_err, 0);
    ex_mc_done = 1'b1;
    #1 check("done_ignored", ctl, E_NORMAL);
    step();
    idle_inputs();
    #1 check("done_perr", protocol_err, 1);

    // Reset mid-MC_WAIT and mid-MEM_WAIT
    do_reset();
    start_mc();
    run_cycles(3, E_MC_WAIT, "rmc_wait");
    reset = 1'b1;
    #1 check("rmc_rst_ctl", ctl, E_RESET);
    step();
    reset = 1'b0;
    #1 check("rmc_run", ctl, E_NORMAL);
    check("rmc_stall", stall_cycles, 0);
    step();
    #1 check("rmc_still_run", ctl, E_NORMAL);
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1 check("rmem_run", ctl, E_NORMAL);
    check("rmem_stall", stall_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clock, reset, both 1-bit inputs; reset is synchronous, active-high; clock is clock; all state changes on posedge clock.
REQ-002 SHALL have inputs: id_rs1[4:0], id_rs2[4:0] (ID source registers); id_uses_rs1, id_uses_rs2 (1-bit, source actually read).
REQ-003 SHALL have inputs: ex_rd[4:0], ex_mem_read (1-bit, EX holds a load), ex_redirect (1-bit, taken branch or jump resolved in EX).
REQ-004 SHALL have inputs: ex_mc_start (1-bit, pulse, multi-cycle mul/div begins in EX), ex_mc_done (1-bit, pulse, result valid), mem_ready (1-bit, data memory able to complete this cycle).
REQ-005 SHALL have outputs: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_bubble (all 1-bit).
REQ-006 SHALL have outputs: stall_cycles[31:0], redirect_count[31:0], mc_timeout (1-bit sticky), protocol_err (1-bit sticky).

Function
REQ-007 SHALL implement states RUN, MC_WAIT, MEM_WAIT.
REQ-008 Priority each cycle: mem_ready=0 > MC_WAIT > ex_redirect > load-use > normal.
REQ-009 Normal (RUN, no hazard): all *_en=1, all flushes/bubble=0.
REQ-010 Load-use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)); response: pc_en=0, if_id_en=0, id_ex_flush=1, others normal; exactly one bubble per detection.
REQ-011 ex_redirect in RUN: if_id_flush=1, id_ex_flush=1, pc_en=1; load-use in same cycle ignored; redirect_count += 1.
REQ-012 mem_ready=0 in any state: enter/hold MEM_WAIT; all *_en=0, no flush/bubble; return to the prior state (RUN or MC_WAIT) the cycle after mem_ready=1, MC timer paused.
REQ-013 ex_mc_start in RUN with mem_ready=1: next state MC_WAIT; timer cleared.
REQ-014 In MC_WAIT: pc_en, if_id_en, id_ex_en = 0; ex_mem_en=1, ex_mem_bubble=1; timer increments per cycle.
REQ-015 ex_mc_done in MC_WAIT: same-cycle release, all *_en=1, ex_mem_bubble=0; next state RUN.
REQ-016 Timer reaching MC_TIMEOUT (64) without done: set mc_timeout, release as REQ-015, return RUN.
REQ-017 ex_redirect and ex_mc_start asserted together: redirect served, mc_start ignored, protocol_err set; ex_mc_done outside MC_WAIT ignored, sets protocol_err.
REQ-018 stall_cycles += 1 each cycle pc_en=0 after reset; both counters saturate at 32'hFFFF_FFFF.
REQ-019 Outputs combinational from state and inputs; counters/flags registered.

Reset
REQ-020 While reset=1: state RUN, timer 0, counters 0, sticky flags 0, all *_en=0, if_id_flush=1, id_ex_flush=1, ex_mem_bubble=1.
REQ-021 Reset mid-MC_WAIT or MEM_WAIT SHALL abandon the operation; first post-reset cycle is RUN normal.

Structure
REQ-022 Package pipe_ctrl_pkg SHALL hold state enum, MC_TIMEOUT=64, CNT_W=32.
REQ-023 One sub-module sat_counter (width-parameterised, saturating, sync clear) SHALL implement both counters.

Verification
REQ-024 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1.
REQ-025 Load-use with ex_rd=0 -> no stall; load-use plus ex_redirect same cycle -> only redirect flushes, redirect_count=1, pc_en=1.
REQ-026 ex_mc_start, done after 10 cycles -> 10 cycles MC_WAIT with ex_mem_bubble=1, release on done cycle, stall_cycles=10.
REQ-027 ex_mc_start, no done -> release after 64 cycles, mc_timeout=1, state RUN.
REQ-028 mem_ready=0 for 3 cycles during MC_WAIT -> all *_en=0 for 3 cycles, timer frozen, MC_WAIT resumed.
REQ-029 ex_redirect and ex_mc_start together -> protocol_err=1, no MC_WAIT; reset asserted mid-MC_WAIT -> RUN, counters 0.
